// File: rtl/u109_pci_master_cycle_if.sv
// rtl/u109_pci_master_cycle_if.sv - CPU request and PCI bus signal bundle for the U109 master cycle sequencer

interface u109_pci_master_cycle_if;
    // CPU-side request
    logic        START;
    logic        RnW;
    logic        IO_CYCLE;
    logic [3:0]  BEn_IN;
    logic        BGn;

    // PCI arbitration and sampled bus state
    logic        GNTn;
    logic        FRAMEn_IN;
    logic        IRDYn_IN;

    // Target response
    logic        DEVSELn;
    logic        TRDYn;
    logic        STOPn;
    logic [31:0] AD_IN;

    // Master-driven PCI control and buffer steering
    logic        PHASEA_D;
    logic        FRAMEn;
    logic        IRDYn;
    logic [3:0]  CBEn;
    logic        CTRL_OE;

    // Status back to the requester
    logic        BUSY;
    logic        DONE;
    logic        ABORT;
    logic        RETRY;
    logic [31:0] RDATA;

    modport master (
        input  START, RnW, IO_CYCLE, BEn_IN, BGn,
        input  GNTn, FRAMEn_IN, IRDYn_IN,
        input  DEVSELn, TRDYn, STOPn, AD_IN,
        output PHASEA_D, FRAMEn, IRDYn, CBEn, CTRL_OE,
        output BUSY, DONE, ABORT, RETRY, RDATA
    );

    modport slave (
        output START, RnW, IO_CYCLE, BEn_IN, BGn,
        output GNTn, FRAMEn_IN, IRDYn_IN,
        output DEVSELn, TRDYn, STOPn, AD_IN,
        input  PHASEA_D, FRAMEn, IRDYn, CBEn, CTRL_OE,
        input  BUSY, DONE, ABORT, RETRY, RDATA
    );
endinterface

// File: rtl/u109_pci_master_cycle.sv
// rtl/u109_pci_master_cycle.sv - single-data-phase PCI master cycle sequencer

module u109_pci_master_cycle #(
    parameter int DEVSEL_TIMEOUT = 5,
    parameter int TRDY_TIMEOUT   = 16
) (
    input  logic                       CLK33,
    input  logic                       RESETn,
    u109_pci_master_cycle_if.master    bus
);

    localparam logic [4:0] DEVSEL_LAST = 5'(DEVSEL_TIMEOUT - 1);
    localparam logic [4:0] TRDY_LAST   = 5'(TRDY_TIMEOUT - 1);
    localparam logic [4:0] CNT_MAX     = 5'd31;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PEND,
        ST_ADDR,
        ST_DATA,
        ST_TURN
    } state_t;

    state_t      state_q, state_d;

    // Request captured with START; held for the whole cycle
    logic        rnw_q, rnw_d;
    logic        io_q, io_d;
    logic [3:0]  ben_q, ben_d;

    // Data-phase clock count, used for the DEVSEL and TRDY timeouts
    logic [4:0]  cnt_q, cnt_d;

    // Registered outputs; next values are decoded from the next state
    logic        phase_a_q, phase_a_d;
    logic        framen_q, framen_d;
    logic        irdyn_q, irdyn_d;
    logic [3:0]  cben_q, cben_d;
    logic        ctrl_oe_q, ctrl_oe_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        abort_q, abort_d;
    logic        retry_q, retry_d;
    logic [31:0] rdata_q, rdata_d;

    // State, request latch, counter and output registers
    always_ff @(posedge CLK33 or negedge RESETn) begin
        if (!RESETn) begin
            state_q   <= ST_IDLE;
            rnw_q     <= 1'b0;
            io_q      <= 1'b0;
            ben_q     <= 4'hF;
            cnt_q     <= 5'd0;
            phase_a_q <= 1'b1;
            framen_q  <= 1'b1;
            irdyn_q   <= 1'b1;
            cben_q    <= 4'hF;
            ctrl_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            retry_q   <= 1'b0;
            rdata_q   <= 32'h0;
        end else begin
            state_q   <= state_d;
            rnw_q     <= rnw_d;
            io_q      <= io_d;
            ben_q     <= ben_d;
            cnt_q     <= cnt_d;
            phase_a_q <= phase_a_d;
            framen_q  <= framen_d;
            irdyn_q   <= irdyn_d;
            cben_q    <= cben_d;
            ctrl_oe_q <= ctrl_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            abort_q   <= abort_d;
            retry_q   <= retry_d;
            rdata_q   <= rdata_d;
        end
    end

    // Next-state, outcome evaluation and output decode
    always_comb begin
        state_d = state_q;
        rnw_d   = rnw_q;
        io_d    = io_q;
        ben_d   = ben_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        retry_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.START && !bus.BGn) begin
                    rnw_d   = bus.RnW;
                    io_d    = bus.IO_CYCLE;
                    ben_d   = bus.BEn_IN;
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                // Wait for grant and an idle bus (no FRAME, no IRDY)
                if (!bus.GNTn && bus.FRAMEn_IN && bus.IRDYn_IN) begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                cnt_d   = 5'd0;
                state_d = ST_DATA;
            end
            ST_DATA: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 5'd1;
                end
                // TRDY outranks STOP so a disconnect-with-data still completes
                if (!bus.TRDYn) begin
                    done_d  = 1'b1;
                    state_d = ST_TURN;
                    if (rnw_q) begin
                        rdata_d = bus.AD_IN;
                    end
                end else if (!bus.STOPn && !bus.DEVSELn) begin
                    retry_d = 1'b1;
                    state_d = ST_TURN;
                end else if (!bus.STOPn) begin
                    abort_d = 1'b1;
                    state_d = ST_TURN;
                end else if (bus.DEVSELn && cnt_q == DEVSEL_LAST) begin
                    abort_d = 1'b1;
                    state_d = ST_TURN;
                end else if (!bus.DEVSELn && cnt_q == TRDY_LAST) begin
                    abort_d = 1'b1;
                    state_d = ST_TURN;
                end
            end
            ST_TURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        phase_a_d = 1'b1;
        framen_d  = 1'b1;
        irdyn_d   = 1'b1;
        cben_d    = 4'hF;
        ctrl_oe_d = 1'b0;
        busy_d    = 1'b1;

        case (state_d)
            ST_IDLE: begin
                busy_d = 1'b0;
            end
            ST_ADDR: begin
                framen_d  = 1'b0;
                ctrl_oe_d = 1'b1;
                // I/O: 001x, memory: 011x; bit 0 set for writes
                cben_d    = {1'b0, ~io_d, 1'b1, ~rnw_d};
            end
            ST_DATA: begin
                // Single data phase: FRAME already released, IRDY asserted
                phase_a_d = 1'b0;
                irdyn_d   = 1'b0;
                cben_d    = ben_d;
                ctrl_oe_d = 1'b1;
            end
            ST_TURN: begin
                // Drive the control lines high for one clock before release
                ctrl_oe_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.PHASEA_D = phase_a_q;
    assign bus.FRAMEn   = framen_q;
    assign bus.IRDYn    = irdyn_q;
    assign bus.CBEn     = cben_q;
    assign bus.CTRL_OE  = ctrl_oe_q;
    assign bus.BUSY     = busy_q;
    assign bus.DONE     = done_q;
    assign bus.ABORT    = abort_q;
    assign bus.RETRY    = retry_q;
    assign bus.RDATA    = rdata_q;

endmodule

// File: tb/tb_u109_pci_master_cycle.sv
// tb/tb_u109_pci_master_cycle.sv - directed self-checking bench for the U109 PCI master cycle sequencer

module tb_u109_pci_master_cycle;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    u109_pci_master_cycle_if bus();

    u109_pci_master_cycle #(
        .DEVSEL_TIMEOUT (5),
        .TRDY_TIMEOUT   (16)
    ) dut (
        .CLK33  (clk),
        .RESETn (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #15 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Issue START at the current negedge and advance to the first DATA clock
    task automatic begin_cycle(input string tag, input logic rnw, input logic io,
                               input logic [3:0] ben, input logic [3:0] cmd);
        bus.START    = 1'b1;
        bus.RnW      = rnw;
        bus.IO_CYCLE = io;
        bus.BEn_IN   = ben;
        step();
        bus.START = 1'b0;
        chk({tag, "_pend_busy"}, 32'(bus.BUSY), 32'd1);
        step();
        chk({tag, "_addr_cbe"}, 32'(bus.CBEn), 32'(cmd));
        chk({tag, "_addr_frame"}, 32'(bus.FRAMEn), 32'd0);
        chk({tag, "_addr_phasea"}, 32'(bus.PHASEA_D), 32'd1);
        step();
        chk({tag, "_data0_phasea"}, 32'(bus.PHASEA_D), 32'd0);
        chk({tag, "_data0_cbe"}, 32'(bus.CBEn), 32'(ben));
    endtask

    task automatic release_target();
        bus.DEVSELn = 1'b1;
        bus.TRDYn   = 1'b1;
        bus.STOPn   = 1'b1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n        = 1'b0;
        bus.START    = 1'b0;
        bus.RnW      = 1'b0;
        bus.IO_CYCLE = 1'b0;
        bus.BEn_IN   = 4'hF;
        bus.BGn      = 1'b0;
        bus.GNTn     = 1'b0;
        bus.FRAMEn_IN = 1'b1;
        bus.IRDYn_IN = 1'b1;
        bus.DEVSELn  = 1'b1;
        bus.TRDYn    = 1'b1;
        bus.STOPn    = 1'b1;
        bus.AD_IN    = 32'h0;

        // Reset state
        step();
        chk("rst_phasea", 32'(bus.PHASEA_D), 32'd1);
        chk("rst_frame", 32'(bus.FRAMEn), 32'd1);
        chk("rst_irdy", 32'(bus.IRDYn), 32'd1);
        chk("rst_cbe", 32'(bus.CBEn), 32'hF);
        chk("rst_oe", 32'(bus.CTRL_OE), 32'd0);
        chk("rst_busy", 32'(bus.BUSY), 32'd0);
        chk("rst_outcome", 32'({bus.DONE, bus.ABORT, bus.RETRY}), 32'd0);
        chk("rst_rdata", bus.RDATA, 32'h0);
        rst_n = 1'b1;

        // Memory read: DEVSEL at DATA clk 1, TRDY at clk 2
        begin_cycle("mrd", 1'b1, 1'b0, 4'h0, 4'b0110);
        chk("mrd_data0_irdy", 32'(bus.IRDYn), 32'd0);
        chk("mrd_data0_frame", 32'(bus.FRAMEn), 32'd1);
        step();
        chk("mrd_data1_phasea", 32'(bus.PHASEA_D), 32'd0);
        bus.DEVSELn = 1'b0;
        step();
        chk("mrd_data2_phasea", 32'(bus.PHASEA_D), 32'd0);
        bus.TRDYn = 1'b0;
        bus.AD_IN = 32'hDEADBEEF;
        step();
        release_target();
        chk("mrd_turn_phasea", 32'(bus.PHASEA_D), 32'd1);
        chk("mrd_turn_outcome", 32'({bus.DONE, bus.ABORT, bus.RETRY}), 32'b100);
        chk("mrd_turn_oe", 32'(bus.CTRL_OE), 32'd1);
        chk("mrd_rdata", bus.RDATA, 32'hDEADBEEF);
        step();
        chk("mrd_idle_done", 32'(bus.DONE), 32'd0);
        chk("mrd_idle_oe", 32'(bus.CTRL_OE), 32'd0);
        chk("mrd_idle_busy", 32'(bus.BUSY), 32'd0);

        // I/O write with immediate DEVSEL+TRDY: one DATA clock, RDATA kept
        bus.AD_IN = 32'h11112222;
        begin_cycle("iow", 1'b0, 1'b1, 4'b1110, 4'b0011);
        bus.DEVSELn = 1'b0;
        bus.TRDYn   = 1'b0;
        step();
        release_target();
        chk("iow_turn_phasea", 32'(bus.PHASEA_D), 32'd1);
        chk("iow_turn_outcome", 32'({bus.DONE, bus.ABORT, bus.RETRY}), 32'b100);
        chk("iow_rdata_kept", bus.RDATA, 32'hDEADBEEF);
        step();

        // No target: master abort after exactly 5 DATA clocks
        begin_cycle("nodev", 1'b1, 1'b0, 4'h3, 4'b0110);
        repeat (4) step();
        chk("nodev_data4_phasea", 32'(bus.PHASEA_D), 32'd0);
        chk("nodev_data4_abort", 32'(bus.ABORT), 32'd0);
        step();
        chk("nodev_turn_outcome", 32'({bus.DONE, bus.ABORT, bus.RETRY}), 32'b010);
        step();
        chk("nodev_idle_ctrl", 32'({bus.FRAMEn, bus.IRDYn, bus.CTRL_OE}), 32'b110);
        chk("nodev_rdata_kept", bus.RDATA, 32'hDEADBEEF);

        // Retry: DEVSEL, then STOP without TRDY at clk 3
        begin_cycle("rty", 1'b1, 1'b0, 4'h0, 4'b0110);
        bus.DEVSELn = 1'b0;
        repeat (3) step();
        chk("rty_data3_phasea", 32'(bus.PHASEA_D), 32'd0);
        bus.STOPn = 1'b0;
        step();
        release_target();
        chk("rty_turn_outcome", 32'({bus.DONE, bus.ABORT, bus.RETRY}), 32'b001);
        step();

        // Target abort: STOP without DEVSEL
        begin_cycle("tabt", 1'b0, 1'b0, 4'h0, 4'b0111);
        bus.STOPn = 1'b0;
        step();
        release_target();
        chk("tabt_turn_outcome", 32'({bus.DONE, bus.ABORT, bus.RETRY}), 32'b010);
        step();

        // TRDY and STOP together: data transfers, DONE wins
        begin_cycle("both", 1'b1, 1'b1, 4'h5, 4'b0010);
        bus.DEVSELn = 1'b0;
        bus.TRDYn   = 1'b0;
        bus.STOPn   = 1'b0;
        bus.AD_IN   = 32'h12345678;
        step();
        release_target();
        chk("both_turn_outcome", 32'({bus.DONE, bus.ABORT, bus.RETRY}), 32'b100);
        chk("both_rdata", bus.RDATA, 32'h12345678);
        step();

        // TRDY latency abort: DEVSEL held, no TRDY for 16 clocks
        begin_cycle("lat", 1'b1, 1'b0, 4'h0, 4'b0110);
        bus.DEVSELn = 1'b0;
        repeat (15) step();
        chk("lat_data15_phasea", 32'(bus.PHASEA_D), 32'd0);
        chk("lat_data15_abort", 32'(bus.ABORT), 32'd0);
        step();
        release_target();
        chk("lat_turn_outcome", 32'({bus.DONE, bus.ABORT, bus.RETRY}), 32'b010);
        step();

        // Grant withheld: hold in PEND; second START while busy is dropped
        bus.GNTn     = 1'b1;
        bus.START    = 1'b1;
        bus.RnW      = 1'b1;
        bus.IO_CYCLE = 1'b0;
        bus.BEn_IN   = 4'h0;
        for (int i = 0; i < 10; i++) begin
            step();
            bus.START = (i == 3);
            if (i == 0 || i == 9) begin
                chk($sformatf("pend%0d_oe", i), 32'(bus.CTRL_OE), 32'd0);
                chk($sformatf("pend%0d_busy", i), 32'(bus.BUSY), 32'd1);
            end
        end
        bus.START    = 1'b0;
        bus.GNTn     = 1'b0;
        bus.IRDYn_IN = 1'b0;
        step();
        chk("pend_busbusy_frame", 32'({bus.FRAMEn, bus.CTRL_OE}), 32'b10);
        bus.IRDYn_IN = 1'b1;
        step();
        chk("pend_addr_cbe", 32'(bus.CBEn), 32'b0110);
        chk("pend_addr_frame", 32'(bus.FRAMEn), 32'd0);
        step();
        bus.DEVSELn = 1'b0;
        bus.TRDYn   = 1'b0;
        bus.AD_IN   = 32'hCAFEF00D;
        step();
        release_target();
        chk("pend_turn_done", 32'(bus.DONE), 32'd1);
        step();
        step();
        chk("noqueue_busy", 32'(bus.BUSY), 32'd0);

        // START while BGn=1 is ignored
        bus.BGn   = 1'b1;
        bus.START = 1'b1;
        step();
        bus.START = 1'b0;
        chk("bgn_busy0", 32'(bus.BUSY), 32'd0);
        step();
        chk("bgn_busy1", 32'(bus.BUSY), 32'd0);
        bus.BGn = 1'b0;

        // Reset asserted mid-DATA: immediate release, no outcome
        begin_cycle("rstd", 1'b1, 1'b0, 4'h0, 4'b0110);
        bus.DEVSELn = 1'b0;
        step();
        #5;
        rst_n = 1'b0;
        #1;
        chk("rstd_oe", 32'(bus.CTRL_OE), 32'd0);
        chk("rstd_phasea", 32'(bus.PHASEA_D), 32'd1);
        chk("rstd_ctrl", 32'({bus.FRAMEn, bus.IRDYn, bus.CBEn}), 32'b111111);
        chk("rstd_busy", 32'(bus.BUSY), 32'd0);
        chk("rstd_rdata", bus.RDATA, 32'h0);
        release_target();
        step();
        rst_n = 1'b1;
        step();
        chk("rstd_post_outcome", 32'({bus.DONE, bus.ABORT, bus.RETRY}), 32'd0);
        chk("rstd_post_busy", 32'(bus.BUSY), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
